// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O responder and the CPU-side decoder.
// Build option: IO_DEBOUNCE_EN selects the debounced switch path in switch_debounce.
package io_pkg;

    localparam logic [3:0] LED_NIBBLE    = 4'h6;
    localparam logic [3:0] SWITCH_NIBBLE = 4'h7;

    localparam logic [1:0] HALF_LO = 2'd0;
    localparam logic [1:0] HALF_HI = 2'd2;

    localparam int IO_W      = 24;
    localparam int IO_DATA_W = 16;

    // Upper half is zero-extended; odd offsets read as zero.
    function automatic logic [IO_DATA_W-1:0] select_half(input logic [IO_W-1:0] v,
                                                         input logic [1:0]      off);
        logic [IO_DATA_W-1:0] r;
        r = '0;
        case (off)
            HALF_LO: r = v[IO_DATA_W-1:0];
            HALF_HI: r = {{(2*IO_DATA_W-IO_W){1'b0}}, v[IO_W-1:IO_DATA_W]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus shared-counter debouncer for the board switches.
// IO_DEBOUNCE_EN defined: full debounce; undefined: synchronized value passes straight through.
module switch_debounce #(
    parameter int          W               = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter int          CNT_W           = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw_in,
    output logic [W-1:0] sw_stable
);

    logic [W-1:0] sw_meta;
    logic [W-1:0] sw_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     sw_prev;
    logic [CNT_W-1:0] cnt;

    // Any bit change restarts the single shared counter; it saturates at CNT_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_prev   <= '0;
            cnt       <= '0;
            sw_stable <= '0;
        end else if (sw_sync != sw_prev) begin
            sw_prev <= sw_sync;
            cnt     <= '0;
        end else if (cnt == CNT_MAX) begin
            sw_stable <= sw_prev;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_stable <= '0;
        end else begin
            sw_stable <= sw_sync;
        end
    end
`endif

endmodule

// File: rtl/io_responder.sv
// LED output register and switch read-back for the CPU memory-mapped I/O port.
// Switch debouncing depends on IO_DEBOUNCE_EN (see switch_debounce).
module io_responder
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter int          CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led_ctrl,
    input  logic                 switch_ctrl,
    input  logic [1:0]           addr_low,
    input  logic [IO_DATA_W-1:0] wdata,
    output logic [IO_DATA_W-1:0] io_rdata,
    input  logic [IO_W-1:0]      switch_in,
    output logic [IO_W-1:0]      led
);

    logic [IO_W-1:0] sw_stable;

    switch_debounce #(
        .W               (IO_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_switch_debounce (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (switch_in),
        .sw_stable (sw_stable)
    );

    // Upper LED byte takes wdata[7:0]; wdata[15:8] is dropped on that half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= '0;
        end else if (led_ctrl) begin
            case (addr_low)
                HALF_LO: led[IO_DATA_W-1:0]    <= wdata;
                HALF_HI: led[IO_W-1:IO_DATA_W] <= wdata[IO_W-IO_DATA_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        io_rdata = '0;
        if (switch_ctrl) begin
            io_rdata = select_half(sw_stable, addr_low);
        end
    end

endmodule
